// File: rtl/fsm_eg_mult_seg.sv
// Three-state control FSM with a Moore output (yl) and a Mealy output (y0).
// Optional macro FSM_EG_STATE_OUT_EN adds state_o, a direct mirror of the state register.
module fsm_eg_mult_seg (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic       y0,
  output logic       yl
`ifdef FSM_EG_STATE_OUT_EN
  ,
  output logic [1:0] state_o
`endif
);

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } state_t;

  // Plain vector so an unreachable 2'b11 value remains representable.
  logic [1:0] r_state;
  state_t     w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = a ? (b ? S2 : S1) : S0;
      S1:      w_next = a ? S0 : S1;
      S2:      w_next = S0;
      default: w_next = S0;
    endcase
  end

  always_comb begin
    yl = 1'b0;
    y0 = 1'b0;
    case (r_state)
      S0: begin
        yl = 1'b1;
        y0 = a & b;
      end
      S1:      yl = 1'b1;
      default: yl = 1'b0;
    endcase
  end

`ifdef FSM_EG_STATE_OUT_EN
  assign state_o = r_state;
`endif

endmodule

// File: tb/tb_fsm_eg_mult_seg.sv
// Directed test for fsm_eg_mult_seg: reset, all transitions, Mealy timing, mid-run reset, illegal-state recovery.
module tb_fsm_eg_mult_seg;
  logic clk, reset, a, b;
  logic y0, yl;
  int   vectors = 0;
  int   miscompares = 0;

  fsm_eg_mult_seg dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .y0    (y0),
    .yl    (yl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic eyl, input logic ey0);
    chk({tag, "_state"}, dut.r_state, st);
    chk({tag, "_yl"}, {1'b0, yl}, {1'b0, eyl});
    chk({tag, "_y0"}, {1'b0, y0}, {1'b0, ey0});
  endtask

  initial begin
    reset = 1'b1; a = 1'b1; b = 1'b1;
    // Reset held two edges with a=b=1: S0, y0 follows a&b
    tick(); tick();
    chk_all("rst", 2'b00, 1'b1, 1'b1);
    a = 1'b0; #1;
    chk("rst_y0_comb", {1'b0, y0}, 2'b00);

    // Idle in S0
    reset = 1'b0; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("idle", 2'b00, 1'b1, 1'b0);
    end

    // S0 -> S1, hold, back to S0
    a = 1'b1; b = 1'b0;
    tick();
    chk_all("to_s1", 2'b01, 1'b1, 1'b0);
    a = 1'b0; b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("hold_s1", 2'b01, 1'b1, 1'b0);
    end
    a = 1'b1; b = 1'b1; #1;
    chk("s1_y0_ab11", {1'b0, y0}, 2'b00);
    tick();
    chk("s1_to_s0", dut.r_state, 2'b00);

    // S0 -> S2 -> S0, y0 high before the edge
    #1;
    chk("s0_y0_pre", {1'b0, y0}, 2'b01);
    tick();
    chk_all("in_s2", 2'b10, 1'b0, 1'b0);
    a = 1'b0; b = 1'b1;
    tick();
    chk_all("s2_to_s0", 2'b00, 1'b1, 1'b0);

    // Reset from S2 overrides next_state
    a = 1'b1; b = 1'b1;
    tick();
    chk("reach_s2", dut.r_state, 2'b10);
    reset = 1'b1;
    tick();
    chk_all("rst_from_s2", 2'b00, 1'b1, 1'b1);

    // Reset from S1 with a=0 (would otherwise stay S1)
    reset = 1'b0; a = 1'b1; b = 1'b0;
    tick();
    chk("reach_s1", dut.r_state, 2'b01);
    reset = 1'b1; a = 1'b0;
    tick();
    chk_all("rst_from_s1", 2'b00, 1'b1, 1'b0);
    reset = 1'b0;

    // Illegal state recovers to S0 in one edge
    a = 1'b1; b = 1'b1;
    force dut.r_state = 2'b11;
    #1;
    chk("ill_yl", {1'b0, yl}, 2'b00);
    chk("ill_y0", {1'b0, y0}, 2'b00);
    release dut.r_state;
    a = 1'b0; b = 1'b0;
    tick();
    chk_all("ill_recover", 2'b00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
